mux_nto1_pipe: RTL
==================

MUX_NTO1_PIPE -- requirements
Module: mux_nto1_pipe

Interface
REQ-001 The block SHALL expose the parameter WIDTH, default 10, giving the pixel/data width in bits.
REQ-002 The block SHALL expose the parameter NUM_IN, default 4, giving the number of input channels; legal range is 2..16 and need not be a power of 2.
REQ-003 The block SHALL expose the parameter SEL_W, default $clog2(NUM_IN), giving the select width.
REQ-004 The block SHALL expose the parameter DEFAULT_VAL, default 0, giving the value output for an out-of-range select.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; both ports are listed below.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_sel  input  SEL_W  channel select, qualified by in_valid.
REQ-010 in_valid  input  1  upstream beat valid.
REQ-011 in_ready  output  1  block can accept a beat; driven from a register.
REQ-012 out_data  output  WIDTH  selected channel, registered.
REQ-013 out_err  output  1  beat was produced from an out-of-range in_sel (in_sel >= NUM_IN).
REQ-014 out_valid  output  1  output beat valid.
REQ-015 out_ready  input  1  downstream accepts the beat.

Function
REQ-016 The block SHALL accept a beat when in_valid && in_ready, and present a beat as transferred when out_valid && out_ready.
REQ-017 For in_sel < NUM_IN, the accepted beat SHALL carry in_data channel in_sel with out_err=0; otherwise it SHALL carry DEFAULT_VAL with out_err=1.
REQ-018 Latency SHALL be 1 cycle: a beat accepted at edge N appears on out_data/out_valid after edge N when the output register is free.
REQ-019 Storage SHALL be an output register plus one skid register (2 beats total), held under state machine EMPTY/ONE/FULL.
REQ-020 EMPTY: on accept -> ONE (load output register).
REQ-021 ONE: accept without transfer -> FULL (load skid); transfer without accept -> EMPTY; accept with transfer -> ONE (output register reloaded); neither -> ONE.
REQ-022 FULL: transfer -> ONE (skid moves to output register); no accept is possible in FULL.
REQ-023 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, registered so that it has no combinational path from out_ready.
REQ-024 out_valid SHALL be 1 in ONE and FULL.
REQ-025 While out_valid=1 && out_ready=0, out_data and out_err SHALL hold stable.
REQ-026 Beats SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-027 in_data and in_sel SHALL be ignored when in_valid=0; no X-propagation from unselected channels.
REQ-028 Throughput SHALL be 1 beat/cycle while out_ready stays high.

Reset
REQ-029 rst=1 SHALL asynchronously force state EMPTY, out_valid=0, out_data=0, out_err=0, skid contents=0, and in_ready=1.
REQ-030 A reset asserted mid-stream SHALL discard all held beats; the first beat after deassertion SHALL be accepted normally with 1-cycle latency.

Structure
REQ-031 The package mux_pkg SHALL hold the state enum (EMPTY, ONE, FULL) and the default WIDTH/NUM_IN constants.
REQ-032 The channel selection and range check SHALL live in a combinational sub-module mux_nto1_sel (inputs in_data and in_sel; outputs data and err), instantiated once.
REQ-033 Parameter legality (NUM_IN 2..16) SHALL be checked at elaboration.

Verification
REQ-034 Reset then 4 beats, NUM_IN=4, channels {0x3FF,0x155,0x0AA,0x001}, sel 0,1,2,3, out_ready=1 -> out_data 0x3FF,0x155,0x0AA,0x001 on consecutive cycles, each 1 cycle after accept, out_err=0.
REQ-035 NUM_IN=3, sel=3 -> out_data=DEFAULT_VAL (0), out_err=1; next beat sel=2 -> out_err=0.
REQ-036 out_ready=0 while 3 beats are offered -> 2 accepted, in_ready=0 after the 2nd accept, out_data stable; raise out_ready -> beats emerge in order, in_ready returns to 1.
REQ-037 Randomised in_valid/out_ready over 10k beats -> output sequence equals the scoreboard, no loss or duplication, 100% throughput in windows where both are held high.
REQ-038 Reset pulse in state FULL, asynchronous to clk -> out_valid=0 and in_ready=1 immediately; the next beat sel=1 emerges after 1 cycle.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared state encoding and default sizing for mux_nto1_pipe
// Rev 1.0
// ============================================================================
package mux_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 10;
  localparam int unsigned DEFAULT_NUM_IN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mux_nto1_sel.sv
`default_nettype none
// ============================================================================
// mux_nto1_sel : combinational N-to-1 channel select with range check
// Rev 1.0
// ============================================================================
module mux_nto1_sel #(
  parameter int unsigned       WIDTH       = 10,
  parameter int unsigned       NUM_IN      = 4,
  parameter int unsigned       SEL_W       = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        data,
  output logic                    err
);

  // Comparing against each legal index keeps non-power-of-2 NUM_IN in range.
  always_comb begin
    data = DEFAULT_VAL;
    err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(in_sel) == k) begin
        data = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_nto1_pipe.sv
`default_nettype none
// ============================================================================
// mux_nto1_pipe : N-to-1 mux with 1-cycle registered output and skid buffer
// Rev 1.0
// ============================================================================
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int unsigned       WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned       NUM_IN      = DEFAULT_NUM_IN,
  parameter int unsigned       SEL_W       = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (NUM_IN < 2 || NUM_IN > 16 || SEL_W < $clog2(NUM_IN)) begin : g_param_check
    $error("mux_nto1_pipe: NUM_IN must be 2..16 and SEL_W wide enough to address it");
  end

  state_e           state_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_err_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] skid_data_q;
  logic             skid_err_q;
  logic             in_ready_q;

  logic [WIDTH-1:0] sel_data_d;
  logic             sel_err_d;
  logic             accept;
  logic             xfer;

  mux_nto1_sel #(
    .WIDTH       (WIDTH),
    .NUM_IN      (NUM_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .in_data (in_data),
    .in_sel  (in_sel),
    .data    (sel_data_d),
    .err     (sel_err_d)
  );

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // in_ready is registered from the next state, so out_ready never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_data_q  <= sel_data_d;
            out_err_q   <= sel_err_d;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && !xfer) begin
            skid_data_q <= sel_data_d;
            skid_err_q  <= sel_err_d;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end else if (!accept && xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end else if (accept && xfer) begin
            out_data_q  <= sel_data_d;
            out_err_q   <= sel_err_d;
          end
        end
        FULL: begin
          if (xfer) begin
            out_data_q  <= skid_data_q;
            out_err_q   <= skid_err_q;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire
